// File: rtl/mask_erode3x3.sv
// 3x3 binary erosion on a streaming video mask. Control signals are delayed to stay aligned with the mask.
// Optional build macro MASK_ERODE_PAD_ONES_EN: out-of-frame neighbours count as 1 instead of 0.
module mask_erode3x3 #(
  parameter int LINE_LEN = 128,
  parameter int CNT_W    = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic de,
  input  logic hsync,
  input  logic vsync,
  input  logic mask_in,
  output logic de_out,
  output logic hsync_out,
  output logic vsync_out,
  output logic mask_out
);

  localparam int PTR_W = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LINE_LEN - 1);
  localparam logic [CNT_W-1:0] FILL_SAT = CNT_W'(2 * LINE_LEN + 2);

`ifdef MASK_ERODE_PAD_ONES_EN
  localparam logic PAD = 1'b1;
`else
  localparam logic PAD = 1'b0;
`endif

  // Tap word layout: [3]=de, [2]=hsync, [1]=vsync, [0]=mask bit gated by de
  logic [3:0] tap_bot_s;
  logic [3:0] tap_mid_s;
  logic [3:0] tap_top_s;

  logic [3:0] line1_mem_r [LINE_LEN];
  logic [3:0] line2_mem_r [LINE_LEN];
  logic [PTR_W-1:0] wr_ptr_r;

  logic [3:0] bot1_r, bot2_r;
  logic [3:0] mid1_r, mid2_r;
  logic [3:0] top1_r, top2_r;

  logic [CNT_W-1:0] fill_cnt_r;
  logic fill_done_s;
  logic and_s;
  logic mask_nxt_s;

  function automatic logic tap_val(input logic [3:0] t);
    tap_val = t[3] ? t[0] : PAD;
  endfunction

  assign tap_bot_s   = {de, hsync, vsync, de & mask_in};
  assign tap_mid_s   = line1_mem_r[wr_ptr_r];
  assign tap_top_s   = line2_mem_r[wr_ptr_r];
  assign fill_done_s = (fill_cnt_r == FILL_SAT);

  // Line buffers: read-before-write at the same address gives exactly LINE_LEN cycles of delay.
  // Left unreset so they can map to distributed RAM; the fill counter hides stale contents.
  always_ff @(posedge clk) begin
    line1_mem_r[wr_ptr_r] <= tap_bot_s;
    line2_mem_r[wr_ptr_r] <= tap_mid_s;
  end

  // Circular address shared by both line buffers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
    end else if (wr_ptr_r == PTR_LAST) begin
      wr_ptr_r <= {PTR_W{1'b0}};
    end else begin
      wr_ptr_r <= wr_ptr_r + PTR_W'(1);
    end
  end

  // Two column registers per row complete the 3x3 window
  always_ff @(posedge clk) begin
    if (rst) begin
      bot1_r <= 4'b0000;
      bot2_r <= 4'b0000;
      mid1_r <= 4'b0000;
      mid2_r <= 4'b0000;
      top1_r <= 4'b0000;
      top2_r <= 4'b0000;
    end else begin
      bot1_r <= tap_bot_s;
      bot2_r <= bot1_r;
      mid1_r <= tap_mid_s;
      mid2_r <= mid1_r;
      top1_r <= tap_top_s;
      top2_r <= top1_r;
    end
  end

  // Fill counter saturates once every window tap holds post-reset data
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt_r <= {CNT_W{1'b0}};
    end else if (!fill_done_s) begin
      fill_cnt_r <= fill_cnt_r + CNT_W'(1);
    end else begin
      fill_cnt_r <= fill_cnt_r;
    end
  end

  // Erosion: all nine neighbours must be set; the centre pixel must be active
  always_comb begin
    and_s = tap_val(tap_bot_s) & tap_val(bot1_r) & tap_val(bot2_r)
          & tap_val(tap_mid_s) & tap_val(mid1_r) & tap_val(mid2_r)
          & tap_val(tap_top_s) & tap_val(top1_r) & tap_val(top2_r);
    if (mid1_r[3]) begin
      mask_nxt_s = and_s;
    end else begin
      mask_nxt_s = 1'b0;
    end
  end

  // Output stage: centre-column controls plus the eroded bit, all blanked until the window is filled
  always_ff @(posedge clk) begin
    if (rst || !fill_done_s) begin
      de_out    <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      mask_out  <= 1'b0;
    end else begin
      de_out    <= mid1_r[3];
      hsync_out <= mid1_r[2];
      vsync_out <= mid1_r[1];
      mask_out  <= mask_nxt_s;
    end
  end

endmodule
